pipeline_stall_controller: RTL and testbench

- Central stall/flush sequencer for the 5-stage ARM pipeline (IF, ID, EXE, MEM, WB).
- Merges three stall sources into one coherent set of freeze/flush/bubble controls for the pipeline registers: RAW data hazards between ID sources and in-flight EXE/MEM destinations, taken-branch flushes, and multi-cycle data-memory waits.
- Adds a memory-wait timeout watchdog and a stall-cycle performance counter.

---
 rtl/pipeline_stall_controller_pkg.sv | 15 +
 rtl/pipeline_stall_controller_if.sv | 43 ++++
 rtl/pipeline_stall_controller_hazard_match.sv | 14 +
 rtl/pipeline_stall_controller.sv | 124 ++++++++++++
 tb/tb_pipeline_stall_controller.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
// rtl/pipeline_stall_controller_pkg.sv - shared types and constants for the pipeline stall controller
package pipe_ctrl_pkg;

    localparam int REG_W = 4;

    // Instruction word loaded into a pipeline register on bubble/flush
    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// rtl/pipeline_stall_controller_if.sv - pipeline-side signal bundle for the stall controller
interface pipeline_stall_controller_if #(
    parameter int REG_W = pipe_ctrl_pkg::REG_W,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
    logic             id_two_src;
    logic             exe_wb_en;
    logic [REG_W-1:0] exe_dest;
    logic             exe_mem_r_en;
    logic             mem_wb_en;
    logic [REG_W-1:0] mem_dest;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             freeze_if;
    logic             freeze_id;
    logic             bubble_exe;
    logic             flush_id;
    logic             freeze_back;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;

    // Pipeline side: presents stage status, consumes controls
    modport master (
        output id_valid, id_src1, id_src2, id_two_src,
        output exe_wb_en, exe_dest, exe_mem_r_en,
        output mem_wb_en, mem_dest, branch_taken, mem_req, mem_ready,
        input  freeze_if, freeze_id, bubble_exe, flush_id, freeze_back,
        input  mem_timeout, stall_count
    );

    // Controller side
    modport slave (
        input  id_valid, id_src1, id_src2, id_two_src,
        input  exe_wb_en, exe_dest, exe_mem_r_en,
        input  mem_wb_en, mem_dest, branch_taken, mem_req, mem_ready,
        output freeze_if, freeze_id, bubble_exe, flush_id, freeze_back,
        output mem_timeout, stall_count
    );
endinterface

// File: rtl/pipeline_stall_controller_hazard_match.sv
// rtl/pipeline_stall_controller_hazard_match.sv - source/destination register match for one in-flight stage
module hazard_match #(
    parameter int REG_W = pipe_ctrl_pkg::REG_W
) (
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             two_src,
    input  logic [REG_W-1:0] dest,
    input  logic             wb_en,
    output logic             hit
);
    // src2 only counts when the ID instruction actually reads it
    assign hit = wb_en & ((dest == src1) | (two_src & (dest == src2)));
endmodule

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - merges data, branch and memory stalls into pipeline freeze/flush controls
module pipeline_stall_controller #(
    parameter int FORWARDING  = 1,
    parameter int REG_W       = pipe_ctrl_pkg::REG_W,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input logic                        clk,
    input logic                        rst,
    pipeline_stall_controller_if.slave bus
);
    import pipe_ctrl_pkg::*;

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    state_t           state, state_nxt;
    logic [WC_W-1:0]  wait_cnt, wait_cnt_nxt;
    logic             timeout_set;
    logic             timeout_q;
    logic [CNT_W-1:0] stall_cnt;
    logic             hit_exe, hit_mem, data_hz, mem_wait;
    logic             f_if, f_id, bub, flush, f_back;

    hazard_match #(.REG_W(REG_W)) u_match_exe (
        .src1    (bus.id_src1),
        .src2    (bus.id_src2),
        .two_src (bus.id_two_src),
        .dest    (bus.exe_dest),
        .wb_en   (bus.exe_wb_en),
        .hit     (hit_exe)
    );

    hazard_match #(.REG_W(REG_W)) u_match_mem (
        .src1    (bus.id_src1),
        .src2    (bus.id_src2),
        .two_src (bus.id_two_src),
        .dest    (bus.mem_dest),
        .wb_en   (bus.mem_wb_en),
        .hit     (hit_mem)
    );

    // With forwarding only a load in EXE cannot be bypassed in time
    assign data_hz  = bus.id_valid & ((FORWARDING != 0) ? (hit_exe & bus.exe_mem_r_en)
                                                        : (hit_exe | hit_mem));
    assign mem_wait = bus.mem_req & ~bus.mem_ready;

    // Next-state: track consecutive memory-wait cycles, trap on timeout
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        timeout_set  = 1'b0;
        case (state)
            RUN: begin
                if (mem_wait) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WC_W'(1);
                end
            end
            MEM_WAIT: begin
                if (!mem_wait) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == WC_W'(MEM_TIMEOUT)) begin
                    state_nxt   = ERR;
                    timeout_set = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + WC_W'(1);
                end
            end
            ERR:     state_nxt = ERR;
            default: state_nxt = RUN;
        endcase
    end

    // Priority mux: error/mem freeze > branch squash > data-hazard stall
    always_comb begin
        f_if   = 1'b0;
        f_id   = 1'b0;
        bub    = 1'b0;
        flush  = 1'b0;
        f_back = 1'b0;
        if (!rst) begin
            if ((state == ERR) || mem_wait) begin
                f_if   = 1'b1;
                f_id   = 1'b1;
                f_back = 1'b1;
            end else if (bus.branch_taken) begin
                flush = 1'b1;
                bub   = 1'b1;
            end else if (data_hz) begin
                f_if = 1'b1;
                f_id = 1'b1;
                bub  = 1'b1;
            end
        end
    end

    // State, wait counter, sticky timeout flag and saturating stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
            if (f_if && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.freeze_if   = f_if;
    assign bus.freeze_id   = f_id;
    assign bus.bubble_exe  = bub;
    assign bus.flush_id    = flush;
    assign bus.freeze_back = f_back;
    assign bus.mem_timeout = timeout_q;
    assign bus.stall_count = stall_cnt;
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - directed self-checking bench for pipeline_stall_controller
module tb_pipeline_stall_controller;
    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic       branch_taken, mem_req, mem_ready;
    logic [3:0] id_src1, id_src2, exe_dest, mem_dest;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state, index 0 = DUT a (forwarding, timeout 8, 16-bit count),
    // index 1 = DUT b (no forwarding, timeout 255, 4-bit count)
    int m_wait [2] = '{0, 0};
    bit m_err  [2] = '{0, 0};
    int m_cnt  [2] = '{0, 0};
    int m_to   [2] = '{8, 255};
    int m_max  [2] = '{65535, 15};
    bit m_fwd  [2] = '{1, 0};

    always #5 clk = ~clk;

    pipeline_stall_controller_if #(.REG_W(4), .CNT_W(16)) a_if ();
    pipeline_stall_controller_if #(.REG_W(4), .CNT_W(4))  b_if ();

    assign a_if.id_valid = id_valid;      assign b_if.id_valid = id_valid;
    assign a_if.id_src1 = id_src1;        assign b_if.id_src1 = id_src1;
    assign a_if.id_src2 = id_src2;        assign b_if.id_src2 = id_src2;
    assign a_if.id_two_src = id_two_src;  assign b_if.id_two_src = id_two_src;
    assign a_if.exe_wb_en = exe_wb_en;    assign b_if.exe_wb_en = exe_wb_en;
    assign a_if.exe_dest = exe_dest;      assign b_if.exe_dest = exe_dest;
    assign a_if.exe_mem_r_en = exe_mem_r_en; assign b_if.exe_mem_r_en = exe_mem_r_en;
    assign a_if.mem_wb_en = mem_wb_en;    assign b_if.mem_wb_en = mem_wb_en;
    assign a_if.mem_dest = mem_dest;      assign b_if.mem_dest = mem_dest;
    assign a_if.branch_taken = branch_taken; assign b_if.branch_taken = branch_taken;
    assign a_if.mem_req = mem_req;        assign b_if.mem_req = mem_req;
    assign a_if.mem_ready = mem_ready;    assign b_if.mem_ready = mem_ready;

    pipeline_stall_controller #(.FORWARDING(1), .REG_W(4), .MEM_TIMEOUT(8), .CNT_W(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    pipeline_stall_controller #(.FORWARDING(0), .REG_W(4), .MEM_TIMEOUT(255), .CNT_W(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected controls {freeze_if, freeze_id, bubble_exe, flush_id, freeze_back}
    function automatic logic [4:0] model_ctrl(input bit fwd, input bit err);
        bit he, hm, hz, mw;
        if (rst) return 5'b00000;
        he = id_valid && exe_wb_en && (exe_dest == id_src1 || (id_two_src && exe_dest == id_src2));
        hm = id_valid && mem_wb_en && (mem_dest == id_src1 || (id_two_src && mem_dest == id_src2));
        hz = fwd ? (he && exe_mem_r_en) : (he || hm);
        mw = mem_req && !mem_ready;
        if (err || mw)    return 5'b11001;
        if (branch_taken) return 5'b00110;
        if (hz)           return 5'b11100;
        return 5'b00000;
    endfunction

    // Every cycle: compare both DUTs against the model, then advance the model past the next edge
    always @(negedge clk) begin
        logic [4:0] e [2];
        bit mw;
        e[0] = model_ctrl(m_fwd[0], m_err[0]);
        e[1] = model_ctrl(m_fwd[1], m_err[1]);
        chk("a_ctrl", {a_if.freeze_if, a_if.freeze_id, a_if.bubble_exe, a_if.flush_id, a_if.freeze_back}, e[0]);
        chk("b_ctrl", {b_if.freeze_if, b_if.freeze_id, b_if.bubble_exe, b_if.flush_id, b_if.freeze_back}, e[1]);
        chk("a_timeout", a_if.mem_timeout, m_err[0]);
        chk("b_timeout", b_if.mem_timeout, m_err[1]);
        chk("a_count", a_if.stall_count, m_cnt[0]);
        chk("b_count", b_if.stall_count, m_cnt[1]);
        mw = mem_req && !mem_ready;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_wait[i] = 0;
                m_err[i]  = 0;
                m_cnt[i]  = 0;
            end else begin
                if (e[i][4] && m_cnt[i] < m_max[i]) m_cnt[i]++;
                if (!m_err[i]) begin
                    if (!mw)                     m_wait[i] = 0;
                    else if (m_wait[i] == m_to[i]) m_err[i] = 1;
                    else                         m_wait[i]++;
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic v, input logic [3:0] s1, input logic [3:0] s2,
                       input logic two, input logic ewb, input logic [3:0] ed, input logic eld,
                       input logic mwb, input logic [3:0] md, input logic br,
                       input logic mq, input logic mr);
        rst = r; id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = two;
        exe_wb_en = ewb; exe_dest = ed; exe_mem_r_en = eld;
        mem_wb_en = mwb; mem_dest = md; branch_taken = br;
        mem_req = mq; mem_ready = mr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        do_reset();
        do_reset();
        chk("lit_reset_count", a_if.stall_count, 0);
        chk("lit_reset_timeout", a_if.mem_timeout, 0);

        // Load-use: load r3 in EXE, then it moves to MEM
        cyc(0, 1, 3, 0, 0, 1, 3, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 3, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        idle();
        chk("lit_loaduse_a", a_if.stall_count, 1);
        chk("lit_loaduse_b", b_if.stall_count, 2);

        // Two-source masking, then MEM-stage match
        cyc(0, 1, 0, 5, 0, 1, 5, 1, 0, 0, 0, 0, 0);
        chk("lit_mask_no_stall", a_if.freeze_if, 0);
        cyc(0, 1, 0, 5, 1, 1, 5, 1, 0, 0, 0, 0, 0);
        chk("lit_src2_stall", a_if.freeze_if, 1);
        cyc(0, 1, 7, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        chk("lit_memhit_b", b_if.freeze_if, 1);
        chk("lit_memhit_a", a_if.freeze_if, 0);
        idle();

        // Branch beats load-use hazard
        cyc(0, 1, 3, 0, 0, 1, 3, 1, 0, 0, 1, 0, 0);
        chk("lit_branch_flush", {a_if.flush_id, a_if.bubble_exe, a_if.freeze_if}, 3'b110);
        idle();
        chk("lit_branch_count", a_if.stall_count, 2);

        // Memory wait of 4 cycles with branch pending
        do_reset();
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("lit_wait_no_flush", a_if.flush_id, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        chk("lit_ready_flush", {a_if.flush_id, a_if.freeze_back}, 2'b10);
        chk("lit_wait_count", a_if.stall_count, 4);
        idle();

        // Timeout on DUT a (limit 8), then release mem_req
        do_reset();
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) idle();
        chk("lit_timeout_a", a_if.mem_timeout, 1);
        chk("lit_err_freeze_a", a_if.freeze_back, 1);
        chk("lit_no_err_b", b_if.freeze_back, 0);
        chk("lit_err_count_a", a_if.stall_count, 13);
        do_reset();
        idle();
        chk("lit_after_rst", {a_if.mem_timeout, a_if.freeze_if, a_if.freeze_back}, 3'b000);

        // Counter saturation on DUT b (4-bit)
        for (int i = 0; i < 20; i++) cyc(0, 1, 2, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0);
        chk("lit_sat_b", b_if.stall_count, 15);
        chk("lit_nosat_a", a_if.stall_count, 20);
        idle();
        idle();
        chk("lit_sat_hold_b", b_if.stall_count, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
